// File: rtl/botoes_pkg.sv
// Shared types and default timing constants for the push-button front end.
package botoes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } estado_t;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;
  localparam int DEF_CNT_W           = 32;

endpackage

// File: rtl/botoes_pulsos_canal_botao.sv
// One button channel: 2-flop synchroniser, debounce filter and auto-repeat FSM.
// req is combinational; the top registers it after mutual exclusion.
module canal_botao
  import botoes_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic st,
  output logic req
);

  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_MAX  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_MAX  = CNT_W'(REPEAT_PERIOD - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] dc, rc, rc_nxt;
  estado_t          estado, estado_nxt;
  logic             flip, fall;

  assign flip = (s2 != st) && (dc == DB_MAX);
  // Release takes the FSM to IDLE on the very edge st drops, so a repeat
  // strobe that would land on that edge is suppressed.
  assign fall = st && flip;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      st     <= 1'b0;
      dc     <= '0;
      rc     <= '0;
      estado <= IDLE;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == st) begin
        dc <= '0;
      end else if (flip) begin
        st <= s2;
        dc <= '0;
      end else begin
        dc <= dc + 1'b1;
      end
      estado <= estado_nxt;
      rc     <= rc_nxt;
    end
  end

  always_comb begin
    estado_nxt = estado;
    rc_nxt     = rc;
    req        = 1'b0;
    case (estado)
      IDLE: begin
        // st can only be high in IDLE right after its rising edge
        if (st && !fall) begin
          req        = 1'b1;
          rc_nxt     = '0;
          estado_nxt = DELAY;
        end
      end
      DELAY: begin
        if (!st || fall) begin
          rc_nxt     = '0;
          estado_nxt = IDLE;
        end else if (rc == RD_MAX) begin
          req        = 1'b1;
          rc_nxt     = '0;
          estado_nxt = REPEAT;
        end else begin
          rc_nxt = rc + 1'b1;
        end
      end
      REPEAT: begin
        if (!st || fall) begin
          rc_nxt     = '0;
          estado_nxt = IDLE;
        end else if (rc == RP_MAX) begin
          req    = 1'b1;
          rc_nxt = '0;
        end else begin
          rc_nxt = rc + 1'b1;
        end
      end
      default: begin
        rc_nxt     = '0;
        estado_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/botoes_pulsos.sv
// Two debounced auto-repeat button channels feeding mutually exclusive,
// registered one-cycle increment/decrement strobes.
module botoes_pulsos
  import botoes_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_down,
  output logic acrescer,
  output logic decrecer
);

  logic st_up, st_down, up_req, down_req;

  canal_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .CNT_W          (CNT_W)
  ) u_up (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_up),
    .st   (st_up),
    .req  (up_req)
  );

  canal_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .CNT_W          (CNT_W)
  ) u_down (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_down),
    .st   (st_down),
    .req  (down_req)
  );

  // Coincident requests cancel each other; nothing is deferred.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acrescer <= 1'b0;
      decrecer <= 1'b0;
    end else begin
      acrescer <= up_req & st_up & ~down_req;
      decrecer <= down_req & st_down & ~up_req;
    end
  end

endmodule

// File: tb/tb_botoes_pulsos.sv
// Scoreboard bench: stimulus pushes the expected strobe edge and channel,
// a negedge monitor pops and compares whenever a strobe appears.
module tb_botoes_pulsos;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_up, btn_down;
  logic acrescer, decrecer;

  botoes_pulsos #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .CNT_W          (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .acrescer(acrescer),
    .decrecer(decrecer)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic up;
  } exp_t;

  exp_t q[$];
  exp_t got;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  int   e0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic push(input int c, input logic up);
    exp_t e;
    e.cyc = c;
    e.up  = up;
    q.push_back(e);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b0) begin
      tests = tests + 1;
      if (acrescer !== 1'b0 || decrecer !== 1'b0) begin
        fails = fails + 1;
        $display("FAIL reset_out cyc=%0d got acrescer=%b decrecer=%b want 0 0", cyc, acrescer, decrecer);
      end
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL missed_strobe want edge=%0d up=%b, absent at cyc=%0d", q[0].cyc, q[0].up, cyc);
        void'(q.pop_front());
      end
      if (acrescer !== 1'b0 || decrecer !== 1'b0) begin
        tests = tests + 1;
        if (q.size() == 0) begin
          fails = fails + 1;
          $display("FAIL unexpected_strobe cyc=%0d got acrescer=%b decrecer=%b want none", cyc, acrescer, decrecer);
        end else begin
          got = q.pop_front();
          if (got.cyc != cyc || acrescer !== got.up || decrecer !== !got.up) begin
            fails = fails + 1;
            $display("FAIL strobe cyc=%0d got acrescer=%b decrecer=%b want edge=%0d up=%b",
                     cyc, acrescer, decrecer, got.cyc, got.up);
          end
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    edges(3);
    rst_n = 1'b1;
    edges(50);

    // clean press, held 10 cycles
    btn_up = 1'b1;
    e0 = cyc + 1;
    push(e0 + 6, 1'b1);
    edges(10);
    btn_up = 1'b0;
    edges(40);

    // glitches shorter than the debounce window
    btn_down = 1'b1; edges(3);
    btn_down = 1'b0; edges(2);
    btn_down = 1'b1; edges(3);
    btn_down = 1'b0; edges(20);

    // auto-repeat, held 60 cycles
    btn_up = 1'b1;
    e0 = cyc + 1;
    push(e0 + 6,  1'b1);
    push(e0 + 26, 1'b1);
    push(e0 + 34, 1'b1);
    push(e0 + 42, 1'b1);
    push(e0 + 50, 1'b1);
    push(e0 + 58, 1'b1);
    edges(60);
    btn_up = 1'b0;
    edges(30);

    // simultaneous press: all dropped, then up keeps its cadence alone
    btn_up   = 1'b1;
    btn_down = 1'b1;
    e0 = cyc + 1;
    push(e0 + 66, 1'b1);
    push(e0 + 74, 1'b1);
    push(e0 + 82, 1'b1);
    edges(60);
    btn_down = 1'b0;
    edges(25);
    btn_up = 1'b0;
    edges(30);

    // reset in the middle of repeat, button still held
    btn_up = 1'b1;
    e0 = cyc + 1;
    push(e0 + 6,  1'b1);
    push(e0 + 26, 1'b1);
    edges(30);
    rst_n = 1'b0;
    edges(1);
    rst_n = 1'b1;
    push(e0 + 37, 1'b1);
    push(e0 + 57, 1'b1);
    push(e0 + 65, 1'b1);
    push(e0 + 73, 1'b1);
    edges(45);
    btn_up = 1'b0;
    edges(30);

    tests = tests + 1;
    if (q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL leftover_expected got %0d pending want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/botoes_pulsos.md
Name: botoes_pulsos

Overview:
- Front end for the up/down counter: takes two raw mechanical push-buttons (increment, decrement).
- Synchronises each button, debounces it, and adds an auto-repeat function.
- Emits clean single-cycle `acrescer` / `decrecer` strobes that drive the counter's inputs directly.
- Guarantees the two strobes are never high together.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive cycles a synchronised level must differ from the accepted state before the accepted state flips. Range ≥1.
- REPEAT_DELAY, 25000000: cycles a button must stay accepted-pressed after its press strobe before the first repeat strobe. Range ≥1.
- REPEAT_PERIOD, 5000000: cycles between successive repeat strobes while held. Range ≥1.
- CNT_W, 32: width of the internal debounce and repeat counters. Must hold the largest of the three cycle parameters.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- btn_up  in  1  raw increment button, asynchronous, active-high (pressed = 1).
- btn_down  in  1  raw decrement button, asynchronous, active-high.
- acrescer  out  1  one-cycle increment strobe, registered.
- decrecer  out  1  one-cycle decrement strobe, registered.

Behaviour:
- Reset (`rst_n` = 0 at a clk edge):
  - synchroniser flops, accepted states, counters and outputs all go to 0;
  - both FSMs go to IDLE;
  - takes effect at that edge, even mid-debounce or mid-repeat;
  - the first edge with `rst_n` = 1 starts from the clean state;
  - a button already held at reset release is debounced as a fresh press.
- Synchroniser: 2 flops per button; the synchronised level is `s`.
- Debounce, per channel, with accepted state `st` and counter `dc`:
  - `s == st`: `dc` ← 0.
  - `s != st` and `dc == DEBOUNCE_CYCLES-1`: `st` ← `s`, `dc` ← 0.
  - otherwise: `dc` ← `dc` + 1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes `st`.
- Press latency: raw input high and stable from clk edge E0 (first edge sampling 1):
  - `s` is high after E1;
  - `st` flips at edge E1+DEBOUNCE_CYCLES;
  - the strobe is high for exactly the one cycle following edge E2+DEBOUNCE_CYCLES.
- Release: the `st` 1→0 transition produces no strobe.
- Repeat FSM, per channel, with counter `rc`:
  - IDLE: on `st` 0→1, raise the channel strobe, `rc` ← 0, go to DELAY.
  - DELAY: `st` = 0 → IDLE. Else `rc` increments; when `rc == REPEAT_DELAY-1`, strobe, `rc` ← 0, go to REPEAT.
  - REPEAT: `st` = 0 → IDLE. Else `rc` increments; when `rc == REPEAT_PERIOD-1`, strobe and `rc` ← 0.
  - Release (`st` → 0) returns to IDLE at the same edge `st` falls; no strobe that cycle.
- Mutual exclusion:
  - `acrescer` ← `up_req` & ~`down_req`;
  - `decrecer` ← `down_req` & ~`up_req`.
  - Coincident requests are both dropped, never deferred.
  - Each FSM keeps running independently regardless of the other channel.
- Strobes are always exactly 1 cycle wide; no strobe is ever issued while `st` = 0.
- Counters saturate nowhere: they are compared and cleared before reaching their limits.

Decomposition:
- Package `botoes_pkg` holds:
  - FSM state enum: IDLE, DELAY, REPEAT (2 bits);
  - default-parameter localparams.
- Sub-module `canal_botao`: 2-flop sync + debounce + repeat FSM; outputs the `st` level and the request strobe.
- Top level instantiates `canal_botao` twice and adds the exclusion/output registers.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset then idle: hold `rst_n`=0 for 3 edges, buttons 0 → `acrescer`=`decrecer`=0 throughout and for 50 cycles after release.
- Clean press: `btn_up` rises before edge E0 and is held 10 cycles, then released → `acrescer` high only in the cycle after E6; `decrecer` stays 0; no further strobes.
- Glitch rejection: `btn_down` high for 3 cycles, low 2, high 3, low → no `decrecer` strobe, `st` stays 0.
- Auto-repeat: `btn_up` held 60 cycles → strobes at E6, E26, E34, E42, E50, E58; none after release.
- Simultaneous: `btn_up` and `btn_down` pressed the same cycle and held → no strobe on either output ever. Then release `btn_down` only → next `acrescer` strobes continue on `up`'s existing repeat cadence.
- Reset mid-repeat: `btn_up` held, `rst_n`=0 for 1 edge at E30 → no strobe in the cycle after E30. Press restarts: first strobe 7 edges after the reset edge, then follows the normal DELAY/REPEAT cadence.
